pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control for the 5-stage core (IF/ID/EX/MEM/WB).
- Replaces the fixed hazard detector. Adds:
  - configurable register-address width and zero-register rule;
  - variable-latency data-memory stall via a mem_req/mem_ready handshake, with a timeout flag;
  - branch flush deferral during memory stalls;
  - a halt-drain state machine.
- Drives the stall, flush and forward-select controls for all pipeline registers and the EX operand muxes.

Parameters:
- REG_AW, 5: register-address width.
- ZERO_REG, 1: when 1, register 0 never causes a hazard or a forward.
- TMO_W, 8: memory-wait counter width; timeout at 2^TMO_W-1 cycles.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- id_valid, id_rs1_used, id_rs2_used, id_halt  in  1 each  ID-stage qualifiers.
- id_rs1, id_rs2  in  REG_AW  ID source registers.
- ex_valid, ex_rd_en, ex_is_load  in  1 each  EX qualifiers.
- ex_rs1, ex_rs2, ex_rd  in  REG_AW  EX sources and destination.
- mem_valid, mem_rd_en, mem_is_load, mem_req  in  1 each  MEM qualifiers; mem_req = data access issued.
- mem_rd  in  REG_AW  MEM destination.
- mem_ready  in  1  data memory completes the access this cycle.
- wb_valid, wb_rd_en, wb_halt  in  1 each  WB qualifiers.
- wb_rd  in  REG_AW  WB destination.
- take_branch  in  1  branch resolved taken in MEM.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID.
- bubble_ex  out  1  load NOP into ID/EX.
- stall_all  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- flush_if, flush_id, flush_ex  out  1 each  squash IF/ID, ID/EX, EX/MEM.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 MEM alu_out, 10 WB write data.
- halted  out  1  core halted.
- mem_err  out  1  sticky memory timeout.
- stall_load_cnt, stall_mem_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Match rule, match(r, rd, en, v) = v & en & (r==rd) & !(ZERO_REG & rd==0).
- Forwarding (combinational):
  - fwd_a = 01 if match(ex_rs1, MEM) & !mem_is_load;
  - else 10 if match(ex_rs1, WB);
  - else 00.
  - fwd_b is identical using ex_rs2. MEM has priority over WB.
- load_use = id_valid & ex_is_load & ((id_rs1_used & match(id_rs1, EX)) | (id_rs2_used & match(id_rs2, EX))).
- mem_wait = mem_valid & mem_req & !mem_ready.
- Priority (highest first): HALTED, mem_wait, take_branch, load_use, halt drain.
- mem_wait:
  - stall_if = stall_id = stall_all = 1; bubble_ex = 0; all flushes = 0.
  - A take_branch asserted during the wait is deferred; it takes effect in the cycle mem_ready arrives.
- take_branch (not stalled): flush_if = flush_id = flush_ex = 1; load_use is ignored.
- load_use: stall_if = stall_id = bubble_ex = 1; exactly one bubble per cycle load_use holds.
- States: RUN, DRAIN, HALTED. Reset state is RUN.
- RUN -> DRAIN when id_valid & id_halt & !take_branch & !mem_wait & !load_use.
- DRAIN:
  - stall_if = 1 and flush_if = 1, so no new fetches enter.
  - take_branch returns the machine to RUN; the older branch squashes the halt.
  - wb_valid & wb_halt moves the machine to HALTED.
- HALTED:
  - stall_if, stall_id and stall_all = 1.
  - halted = 1, registered: asserts the cycle after wb_halt is seen.
  - Only rst exits.
- Wait counter:
  - counts consecutive mem_wait cycles and clears when mem_wait = 0;
  - on reaching 2^TMO_W-1, sets mem_err (sticky until rst);
  - the counter saturates and the stall continues.
- Reset values (async, while rst = 1):
  - state RUN; halted = 0; mem_err = 0; wait counter 0; perf counters 0;
  - all stall/flush/bubble outputs 0; fwd_a = fwd_b = 00.
- Reset mid-stall or mid-drain: immediate return to RUN; no flush is pulsed.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_load_cnt increments on each load_use bubble cycle;
  - stall_mem_cnt increments on each mem_wait cycle;
  - flush_cnt increments on each cycle flush_ex = 1;
  - all three saturate at 2^CNT_W-1 and clear on rst.
- Undefined: the counters are not built and the three ports drive constant 0.

Test Plan:
1. Forwarding: MEM rd=3 (ALU), WB rd=3, ex_rs1=3 -> fwd_a=01. With mem_is_load=1 -> fwd_a=10. With rd=0, ZERO_REG=1 -> fwd_a=00.
2. Load-use: ex_is_load=1, ex_rd=7, id_rs2=7, id_rs2_used=1 -> stall_if/stall_id/bubble_ex=1 for one cycle. Next cycle (load in MEM, dependent in EX) -> fwd_b=10 the following cycle.
3. Memory wait: mem_req=1, mem_ready=0 for 4 cycles -> stall_all=1 for 4 cycles. A take_branch pulse in cycle 2 produces flush_if/id/ex=1 only in the mem_ready cycle.
4. Timeout (TMO_W=3): mem_ready held 0 -> mem_err=1 after 7 wait cycles; it stays 1 after mem_ready until rst.
5. Halt: id_halt -> DRAIN with flush_if=1 each cycle; wb_halt 3 cycles later -> halted=1 next cycle, and all stalls stay asserted. A take_branch during DRAIN instead returns the machine to RUN with halted=0.
6. With PIPE_PERF_CNT_EN: 2 load-use bubbles, 4 wait cycles, 1 branch -> stall_load_cnt=2, stall_mem_cnt=4, flush_cnt=1. Without the macro, all three read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall / flush / forward control for the 5-stage core, including
//            memory-wait stalls, deferred branch flush and a halt-drain FSM.
//            Define PIPE_PERF_CNT_EN to build the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 1,
   parameter int TMO_W    = 8,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic              id_halt,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              ex_valid,
   input  logic              ex_rd_en,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_valid,
   input  logic              mem_rd_en,
   input  logic              mem_is_load,
   input  logic              mem_req,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_ready,
   input  logic              wb_valid,
   input  logic              wb_rd_en,
   input  logic              wb_halt,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              take_branch,
   output logic              stall_if,
   output logic              stall_id,
   output logic              bubble_ex,
   output logic              stall_all,
   output logic              flush_if,
   output logic              flush_id,
   output logic              flush_ex,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              halted,
   output logic              mem_err,
   output logic [CNT_W-1:0]  stall_load_cnt,
   output logic [CNT_W-1:0]  stall_mem_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [1:0] c_ST_RUN    = 2'd0;
   localparam logic [1:0] c_ST_DRAIN  = 2'd1;
   localparam logic [1:0] c_ST_HALTED = 2'd2;

   localparam logic [TMO_W-1:0] c_TMO_MAX = {TMO_W{1'b1}};
   localparam logic [TMO_W-1:0] c_TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_br_pend;
   logic [TMO_W-1:0] r_wait_cnt;
   logic             r_mem_err;
   logic             w_mem_wait;
   logic             w_branch;
   logic             w_load_use;

   function automatic logic f_match(input logic [REG_AW-1:0] r,
                                    input logic [REG_AW-1:0] rd,
                                    input logic              en,
                                    input logic              v);
      return v && en && (r == rd) && !((ZERO_REG != 0) && (rd == '0));
   endfunction

   assign w_mem_wait = mem_valid && mem_req && !mem_ready;
   // A branch seen while memory stalls is held and acted on once the access completes
   assign w_branch   = (take_branch || r_br_pend) && !w_mem_wait;
   assign w_load_use = id_valid && ex_is_load &&
                       ((id_rs1_used && f_match(id_rs1, ex_rd, ex_rd_en, ex_valid)) ||
                        (id_rs2_used && f_match(id_rs2, ex_rd, ex_rd_en, ex_valid)));

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (!rst) begin
         if (f_match(ex_rs1, mem_rd, mem_rd_en, mem_valid) && !mem_is_load)
            fwd_a = 2'b01;
         else if (f_match(ex_rs1, wb_rd, wb_rd_en, wb_valid))
            fwd_a = 2'b10;
         if (f_match(ex_rs2, mem_rd, mem_rd_en, mem_valid) && !mem_is_load)
            fwd_b = 2'b01;
         else if (f_match(ex_rs2, wb_rd, wb_rd_en, wb_valid))
            fwd_b = 2'b10;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= c_ST_RUN;
         r_br_pend <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_br_pend <= (r_state != c_ST_HALTED) && w_mem_wait && (take_branch || r_br_pend);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_RUN:
            if (id_valid && id_halt && !w_branch && !w_mem_wait && !w_load_use)
               w_state_nxt = c_ST_DRAIN;
         // A halt already in WB is committed; any branch now in MEM is younger
         c_ST_DRAIN:
            if (wb_valid && wb_halt)
               w_state_nxt = c_ST_HALTED;
            else if (w_branch)
               w_state_nxt = c_ST_RUN;
         c_ST_HALTED:
            w_state_nxt = c_ST_HALTED;
         default:
            w_state_nxt = c_ST_RUN;
      endcase
   end

   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      stall_all = 1'b0;
      flush_if  = 1'b0;
      flush_id  = 1'b0;
      flush_ex  = 1'b0;
      if (!rst) begin
         if ((r_state == c_ST_HALTED) || w_mem_wait) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_all = 1'b1;
         end else if (w_branch) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
            flush_ex = 1'b1;
         end else if (w_load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
         end else if (r_state == c_ST_DRAIN) begin
            stall_if = 1'b1;
            flush_if = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         if (!w_mem_wait)
            r_wait_cnt <= '0;
         else if (r_wait_cnt != c_TMO_MAX)
            r_wait_cnt <= r_wait_cnt + c_TMO_ONE;
         if (w_mem_wait && (r_wait_cnt >= c_TMO_MAX - c_TMO_ONE))
            r_mem_err <= 1'b1;
      end
   end

   assign halted  = (r_state == c_ST_HALTED);
   assign mem_err = r_mem_err;

`ifdef PIPE_PERF_CNT_EN
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_cnt_load;
   logic [CNT_W-1:0] r_cnt_mem;
   logic [CNT_W-1:0] r_cnt_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt_load  <= '0;
         r_cnt_mem   <= '0;
         r_cnt_flush <= '0;
      end else begin
         if (bubble_ex && (r_cnt_load != c_CNT_MAX))
            r_cnt_load <= r_cnt_load + c_CNT_ONE;
         if (w_mem_wait && (r_cnt_mem != c_CNT_MAX))
            r_cnt_mem <= r_cnt_mem + c_CNT_ONE;
         if (flush_ex && (r_cnt_flush != c_CNT_MAX))
            r_cnt_flush <= r_cnt_flush + c_CNT_ONE;
      end
   end

   assign stall_load_cnt = r_cnt_load;
   assign stall_mem_cnt  = r_cnt_mem;
   assign flush_cnt      = r_cnt_flush;
`else
   assign stall_load_cnt = '0;
   assign stall_mem_cnt  = '0;
   assign flush_cnt      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed scenarios plus randomized run against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int C_AW  = 5;
   localparam int C_TMO = 3;
   localparam int C_CW  = 4;
   localparam int C_CNT_SAT = 15;
`ifdef PIPE_PERF_CNT_EN
   localparam bit C_PERF = 1'b1;
`else
   localparam bit C_PERF = 1'b0;
`endif

   // ctl = {stall_if, stall_id, bubble_ex, stall_all, flush_if, flush_id, flush_ex}
   localparam logic [6:0] C_NONE  = 7'b0000000;
   localparam logic [6:0] C_STALL = 7'b1101000;
   localparam logic [6:0] C_FLUSH = 7'b0000111;
   localparam logic [6:0] C_LU    = 7'b1110000;
   localparam logic [6:0] C_DRAIN = 7'b1000100;

   logic clk, rst;
   logic id_valid, id_rs1_used, id_rs2_used, id_halt;
   logic [C_AW-1:0] id_rs1, id_rs2;
   logic ex_valid, ex_rd_en, ex_is_load;
   logic [C_AW-1:0] ex_rs1, ex_rs2, ex_rd;
   logic mem_valid, mem_rd_en, mem_is_load, mem_req, mem_ready;
   logic [C_AW-1:0] mem_rd;
   logic wb_valid, wb_rd_en, wb_halt;
   logic [C_AW-1:0] wb_rd;
   logic take_branch;
   logic stall_if, stall_id, bubble_ex, stall_all, flush_if, flush_id, flush_ex;
   logic [1:0] fwd_a, fwd_b;
   logic halted, mem_err;
   logic [C_CW-1:0] stall_load_cnt, stall_mem_cnt, flush_cnt;
   logic [6:0] ctl;

   int n_vec = 0;
   int n_err = 0;

   assign ctl = {stall_if, stall_id, bubble_ex, stall_all, flush_if, flush_id, flush_ex};

   pipe_hazard_ctrl #(.REG_AW(C_AW), .ZERO_REG(1), .TMO_W(C_TMO), .CNT_W(C_CW)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_halt(id_halt), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .ex_valid(ex_valid), .ex_rd_en(ex_rd_en), .ex_is_load(ex_is_load),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .mem_valid(mem_valid), .mem_rd_en(mem_rd_en), .mem_is_load(mem_is_load),
      .mem_req(mem_req), .mem_rd(mem_rd), .mem_ready(mem_ready),
      .wb_valid(wb_valid), .wb_rd_en(wb_rd_en), .wb_halt(wb_halt), .wb_rd(wb_rd),
      .take_branch(take_branch),
      .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
      .stall_all(stall_all), .flush_if(flush_if), .flush_id(flush_id),
      .flush_ex(flush_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .halted(halted), .mem_err(mem_err),
      .stall_load_cnt(stall_load_cnt), .stall_mem_cnt(stall_mem_cnt),
      .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- helpers
   task automatic clear_inputs();
      id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_halt = 0;
      id_rs1 = '0; id_rs2 = '0;
      ex_valid = 0; ex_rd_en = 0; ex_is_load = 0;
      ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
      mem_valid = 0; mem_rd_en = 0; mem_is_load = 0; mem_req = 0; mem_ready = 0;
      mem_rd = '0;
      wb_valid = 0; wb_rd_en = 0; wb_halt = 0; wb_rd = '0;
      take_branch = 0;
   endtask

   // Returns at a falling edge with rst released; inputs are driven right after.
   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_wait();
      mem_valid = 1; mem_req = 1; mem_ready = 0;
   endtask

   // ---------------------------------------------------------------- reference model
   string m_mode;
   bit    m_pend;
   bit    m_err;
   int    m_wait_run;
   int    m_nl, m_nm, m_nf;
   logic [6:0] e_ctl;
   logic [1:0] e_fa, e_fb;
   bit    e_lu, e_mw, e_br;

   function automatic bit hit(logic [C_AW-1:0] r, logic [C_AW-1:0] rd, logic en, logic v);
      return v && en && (r == rd) && (rd != 0);
   endfunction

   function automatic logic [1:0] fwd_sel(logic [C_AW-1:0] src);
      if (hit(src, mem_rd, mem_rd_en, mem_valid) && !mem_is_load) return 2'b01;
      if (hit(src, wb_rd, wb_rd_en, wb_valid)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic int sat(int v);
      return (v > C_CNT_SAT) ? C_CNT_SAT : v;
   endfunction

   task automatic model_reset();
      m_mode = "RUN"; m_pend = 0; m_err = 0; m_wait_run = 0;
      m_nl = 0; m_nm = 0; m_nf = 0;
   endtask

   task automatic model_predict();
      e_fa = fwd_sel(ex_rs1);
      e_fb = fwd_sel(ex_rs2);
      e_lu = id_valid && ex_is_load &&
             ((id_rs1_used && hit(id_rs1, ex_rd, ex_rd_en, ex_valid)) ||
              (id_rs2_used && hit(id_rs2, ex_rd, ex_rd_en, ex_valid)));
      e_mw = mem_valid && mem_req && !mem_ready;
      e_br = (take_branch || m_pend) && !e_mw;
      if (m_mode == "HALTED" || e_mw) e_ctl = C_STALL;
      else if (e_br)                  e_ctl = C_FLUSH;
      else if (e_lu)                  e_ctl = C_LU;
      else if (m_mode == "DRAIN")     e_ctl = C_DRAIN;
      else                            e_ctl = C_NONE;
   endtask

   task automatic model_advance();
      if (e_ctl == C_LU) m_nl++;
      if (e_mw) m_nm++;
      if (e_ctl == C_FLUSH) m_nf++;
      m_pend = (m_mode != "HALTED") && e_mw && (take_branch || m_pend);
      m_wait_run = e_mw ? m_wait_run + 1 : 0;
      if (m_wait_run >= (1 << C_TMO) - 1) m_err = 1;
      if (m_mode == "RUN") begin
         if (id_valid && id_halt && !e_br && !e_mw && !e_lu) m_mode = "DRAIN";
      end else if (m_mode == "DRAIN") begin
         if (wb_valid && wb_halt) m_mode = "HALTED";
         else if (e_br)           m_mode = "RUN";
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      set_wait();
      take_branch = 1; mem_rd_en = 1; mem_rd = 3; ex_rs1 = 3; ex_rs2 = 3;
      #2;
      n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_NONE); end
      n_vec++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_err++; $display("FAIL reset_fwd: got %b%b expected 0000", fwd_a, fwd_b); end
      @(negedge clk);
      n_vec++; if ({halted, mem_err} !== 2'b00) begin n_err++; $display("FAIL reset_status: got %b%b expected 00", halted, mem_err); end
      n_vec++; if ({stall_load_cnt, stall_mem_cnt, flush_cnt} !== '0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", stall_load_cnt, stall_mem_cnt, flush_cnt); end
      do_reset();
   endtask

   task automatic test_forwarding();
      do_reset();
      mem_valid = 1; mem_rd_en = 1; mem_rd = 3; wb_valid = 1; wb_rd_en = 1; wb_rd = 3;
      ex_rs1 = 3; ex_rs2 = 9;
      #1;
      n_vec++; if (fwd_a !== 2'b01) begin n_err++; $display("FAIL fwd_mem_priority: got %b expected 01", fwd_a); end
      n_vec++; if (fwd_b !== 2'b00) begin n_err++; $display("FAIL fwd_b_nomatch: got %b expected 00", fwd_b); end
      @(negedge clk);
      mem_is_load = 1;
      #1;
      n_vec++; if (fwd_a !== 2'b10) begin n_err++; $display("FAIL fwd_load_in_mem: got %b expected 10", fwd_a); end
      @(negedge clk);
      mem_is_load = 0; mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
      #1;
      n_vec++; if (fwd_a !== 2'b00) begin n_err++; $display("FAIL fwd_zero_reg: got %b expected 00", fwd_a); end
      @(negedge clk);
      mem_rd = 5; wb_rd = 3; ex_rs2 = 3;
      #1;
      n_vec++; if (fwd_b !== 2'b10) begin n_err++; $display("FAIL fwd_b_wb: got %b expected 10", fwd_b); end
   endtask

   task automatic test_load_use();
      do_reset();
      id_valid = 1; id_rs2_used = 1; id_rs2 = 7;
      ex_valid = 1; ex_rd_en = 1; ex_is_load = 1; ex_rd = 7;
      #1;
      n_vec++; if (ctl !== C_LU) begin n_err++; $display("FAIL load_use_bubble: got %b expected %b", ctl, C_LU); end
      @(negedge clk);
      ex_valid = 0; ex_rd_en = 0; ex_is_load = 0; ex_rd = 0;
      mem_valid = 1; mem_rd_en = 1; mem_is_load = 1; mem_rd = 7;
      #1;
      n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL load_use_single: got %b expected %b", ctl, C_NONE); end
      @(negedge clk);
      clear_inputs();
      ex_valid = 1; ex_rs2 = 7; wb_valid = 1; wb_rd_en = 1; wb_rd = 7;
      #1;
      n_vec++; if (fwd_b !== 2'b10) begin n_err++; $display("FAIL load_use_fwd: got %b expected 10", fwd_b); end
   endtask

   task automatic test_mem_wait();
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         set_wait();
         take_branch = (k == 2);
         id_valid = 1; id_rs1_used = 1; id_rs1 = 4;
         ex_valid = 1; ex_rd_en = 1; ex_is_load = 1; ex_rd = 4;
         #1;
         n_vec++; if (ctl !== C_STALL) begin n_err++; $display("FAIL mem_wait_c%0d: got %b expected %b", k, ctl, C_STALL); end
         @(negedge clk);
      end
      take_branch = 0; mem_ready = 1;
      #1;
      n_vec++; if (ctl !== C_FLUSH) begin n_err++; $display("FAIL deferred_flush: got %b expected %b", ctl, C_FLUSH); end
      @(negedge clk);
      clear_inputs();
      #1;
      n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL flush_once: got %b expected %b", ctl, C_NONE); end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         set_wait();
         #1;
         if (k == 7) begin
            n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b expected 0", mem_err); end
         end
         if (k == 8) begin
            n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL tmo_set: got %b expected 1", mem_err); end
         end
         if (k == 10) begin
            n_vec++; if (ctl !== C_STALL) begin n_err++; $display("FAIL tmo_stall_holds: got %b expected %b", ctl, C_STALL); end
         end
         @(negedge clk);
      end
      mem_ready = 1;
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      #1;
      n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b expected 1", mem_err); end
      rst = 1'b1;
      #1;
      n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL tmo_clear: got %b expected 0", mem_err); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_halt();
      do_reset();
      id_valid = 1; id_halt = 1;
      #1;
      n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL halt_enter: got %b expected %b", ctl, C_NONE); end
      @(negedge clk);
      clear_inputs();
      for (int k = 2; k <= 4; k++) begin
         wb_valid = (k == 4); wb_halt = (k == 4);
         #1;
         n_vec++; if ({ctl, halted} !== {C_DRAIN, 1'b0}) begin n_err++; $display("FAIL drain_c%0d: got %b/%b expected %b/0", k, ctl, halted, C_DRAIN); end
         @(negedge clk);
      end
      clear_inputs();
      #1;
      n_vec++; if ({ctl, halted} !== {C_STALL, 1'b1}) begin n_err++; $display("FAIL halted: got %b/%b expected %b/1", ctl, halted, C_STALL); end
      @(negedge clk);
      take_branch = 1;
      #1;
      n_vec++; if ({ctl, halted} !== {C_STALL, 1'b1}) begin n_err++; $display("FAIL halted_stays: got %b/%b expected %b/1", ctl, halted, C_STALL); end

      do_reset();
      id_valid = 1; id_halt = 1;
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      take_branch = 1;
      #1;
      n_vec++; if (ctl !== C_FLUSH) begin n_err++; $display("FAIL drain_branch: got %b expected %b", ctl, C_FLUSH); end
      @(negedge clk);
      clear_inputs();
      #1;
      n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL drain_cancel: got %b expected %b", ctl, C_NONE); end
      @(negedge clk);
      wb_valid = 1; wb_halt = 1;
      @(negedge clk);
      clear_inputs();
      #1;
      n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_squashed: got %b expected 0", halted); end
   endtask

   task automatic test_reset_recovery();
      do_reset();
      set_wait(); take_branch = 1;
      @(negedge clk);
      take_branch = 0; mem_ready = 1;
      #1;
      rst = 1'b1;
      #1;
      n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL rst_mid_stall: got %b expected %b", ctl, C_NONE); end
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      #1;
      n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL rst_no_pending_flush: got %b expected %b", ctl, C_NONE); end
      @(negedge clk);
      id_valid = 1; id_halt = 1;
      @(negedge clk);
      clear_inputs();
      #1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++; if ({ctl, halted} !== {C_NONE, 1'b0}) begin n_err++; $display("FAIL rst_mid_drain: got %b/%b expected %b/0", ctl, halted, C_NONE); end
   endtask

   task automatic test_perf_counters();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         id_valid = 1; id_rs1_used = 1; id_rs1 = 6;
         ex_valid = 1; ex_rd_en = 1; ex_is_load = 1; ex_rd = 6;
         @(negedge clk);
      end
      clear_inputs();
      for (int k = 0; k < 4; k++) begin
         set_wait();
         @(negedge clk);
      end
      mem_ready = 1;
      @(negedge clk);
      clear_inputs();
      take_branch = 1;
      @(negedge clk);
      clear_inputs();
      #1;
      n_vec++; if (stall_load_cnt !== C_CW'(C_PERF ? 2 : 0)) begin n_err++; $display("FAIL perf_load: got %0d expected %0d", stall_load_cnt, C_PERF ? 2 : 0); end
      n_vec++; if (stall_mem_cnt !== C_CW'(C_PERF ? 4 : 0)) begin n_err++; $display("FAIL perf_mem: got %0d expected %0d", stall_mem_cnt, C_PERF ? 4 : 0); end
      n_vec++; if (flush_cnt !== C_CW'(C_PERF ? 1 : 0)) begin n_err++; $display("FAIL perf_flush: got %0d expected %0d", flush_cnt, C_PERF ? 1 : 0); end
      for (int k = 0; k < 20; k++) begin
         set_wait();
         @(negedge clk);
      end
      clear_inputs();
      #1;
      n_vec++; if (stall_mem_cnt !== C_CW'(C_PERF ? C_CNT_SAT : 0)) begin n_err++; $display("FAIL perf_saturate: got %0d expected %0d", stall_mem_cnt, C_PERF ? C_CNT_SAT : 0); end
   endtask

   task automatic test_random();
      logic [3*C_CW-1:0] exp_cnt;
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) begin
            do_reset();
            model_reset();
         end
         id_valid    = ($urandom_range(0, 3) != 0);
         id_rs1_used = $urandom_range(0, 1);
         id_rs2_used = $urandom_range(0, 1);
         id_halt     = ($urandom_range(0, 15) == 0);
         id_rs1      = C_AW'($urandom_range(0, 3));
         id_rs2      = C_AW'($urandom_range(0, 3));
         ex_valid    = ($urandom_range(0, 3) != 0);
         ex_rd_en    = $urandom_range(0, 1);
         ex_is_load  = ($urandom_range(0, 2) == 0);
         ex_rs1      = C_AW'($urandom_range(0, 3));
         ex_rs2      = C_AW'($urandom_range(0, 3));
         ex_rd       = C_AW'($urandom_range(0, 3));
         mem_valid   = ($urandom_range(0, 3) != 0);
         mem_rd_en   = $urandom_range(0, 1);
         mem_is_load = ($urandom_range(0, 2) == 0);
         mem_req     = $urandom_range(0, 1);
         mem_ready   = ((i / 250) % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
         mem_rd      = C_AW'($urandom_range(0, 3));
         wb_valid    = ($urandom_range(0, 3) != 0);
         wb_rd_en    = $urandom_range(0, 1);
         wb_halt     = ($urandom_range(0, 5) == 0);
         wb_rd       = C_AW'($urandom_range(0, 3));
         take_branch = ($urandom_range(0, 7) == 0);
         #1;
         model_predict();
         exp_cnt = C_PERF ? {C_CW'(sat(m_nl)), C_CW'(sat(m_nm)), C_CW'(sat(m_nf))} : '0;
         n_vec++; if (ctl !== e_ctl) begin n_err++; $display("FAIL rand_ctl cyc %0d: got %b expected %b", i, ctl, e_ctl); end
         n_vec++; if ({fwd_a, fwd_b} !== {e_fa, e_fb}) begin n_err++; $display("FAIL rand_fwd cyc %0d: got %b/%b expected %b/%b", i, fwd_a, fwd_b, e_fa, e_fb); end
         n_vec++; if ({halted, mem_err} !== {(m_mode == "HALTED"), m_err}) begin n_err++; $display("FAIL rand_status cyc %0d: got %b%b expected %b%b", i, halted, mem_err, (m_mode == "HALTED"), m_err); end
         n_vec++; if ({stall_load_cnt, stall_mem_cnt, flush_cnt} !== exp_cnt) begin n_err++; $display("FAIL rand_cnt cyc %0d: got %h expected %h", i, {stall_load_cnt, stall_mem_cnt, flush_cnt}, exp_cnt); end
         model_advance();
         @(negedge clk);
      end
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_forwarding();
      test_load_use();
      test_mem_wait();
      test_timeout();
      test_halt();
      test_reset_recovery();
      test_perf_counters();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
